snitch_cluster_boot_master: RTL and testbench



---
 rtl/snitch_cluster_boot_master.sv | 256 +++++++++++++++++++++++++
 tb/tb_snitch_cluster_boot_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_cluster_boot_master.sv
// Purpose: single-beat AXI4 boot master; writes entry point and CLINT wake, then polls EOC.
// Latency: start to first aw_valid 1 cycle; each write 3 cycles (AW, W, B) with ready slaves.
// Backpressure: every valid is registered and held with a stable payload until its ready is sampled.

package snitch_cluster_boot_master_pkg;
    localparam int unsigned AxiAddrWidth = 48;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiIdWidth   = 4;
    localparam int unsigned AxiUserWidth = 1;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [AxiUserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [AxiUserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0]   data;
        logic [AxiDataWidth/8-1:0] strb;
        logic                      last;
        logic [AxiUserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [AxiUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;
endpackage

module snitch_cluster_boot_master
    import snitch_cluster_boot_master_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 48,
    parameter int unsigned          DataWidth    = 64,
    parameter int unsigned          NrCores      = 9,
    parameter logic [AddrWidth-1:0] Scratch1Addr = '0,
    parameter logic [AddrWidth-1:0] ClintSetAddr = '0,
    parameter logic [AddrWidth-1:0] EocAddr      = '0,
    parameter int unsigned          PollInterval = 16,
    parameter int unsigned          PollTimeout  = 0,
    parameter type                  req_t        = axi_req_t,
    parameter type                  rsp_t        = axi_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] entry_i,
    output req_t        req_o,
    input  rsp_t        rsp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [30:0] exit_code_o
);

    localparam logic [2:0]           BeatSize  = 3'($clog2(DataWidth / 8));
    localparam logic [1:0]           BurstIncr = 2'b01;
    // Low NrCores bits set; the subtraction also covers NrCores == DataWidth.
    localparam logic [DataWidth-1:0] WakeMask  = (DataWidth'(1) << NrCores) - DataWidth'(1);

    typedef enum logic [3:0] {
        Idle, WrAw, WrW, WrB, Gap, RdAr, RdR, Done, Error
    } state_t;

    state_t      state;
    req_t        req_q;
    logic        step;
    logic [31:0] entry_q;
    logic [31:0] gap_cnt;
    logic [31:0] poll_cnt;
    logic [31:0] poll_next;
    logic        busy;
    logic        done;
    logic        error;
    logic [30:0] exit_code;

    // Response fields that carry no meaning for a single-ID, single-beat master.
    logic unused_rsp;
    assign unused_rsp = ^rsp_i;

    // Saturating count of completed EOC reads including the one in flight.
    assign poll_next = (poll_cnt == '1) ? poll_cnt : poll_cnt + 32'd1;

    // Boot sequencer: all request fields and status outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= Idle;
            req_q     <= '0;
            step      <= 1'b0;
            entry_q   <= '0;
            gap_cnt   <= '0;
            poll_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            exit_code <= '0;
        end else begin
            case (state)
                Idle: begin
                    if (start_i) begin
                        entry_q         <= entry_i;
                        step            <= 1'b0;
                        busy            <= 1'b1;
                        req_q.aw_valid  <= 1'b1;
                        req_q.aw.addr   <= Scratch1Addr;
                        req_q.aw.len    <= '0;
                        req_q.aw.size   <= BeatSize;
                        req_q.aw.burst  <= BurstIncr;
                        req_q.ar.len    <= '0;
                        req_q.ar.size   <= BeatSize;
                        req_q.ar.burst  <= BurstIncr;
                        req_q.w.strb    <= '1;
                        req_q.w.last    <= 1'b1;
                        state           <= WrAw;
                    end
                end
                WrAw: begin
                    if (rsp_i.aw_ready) begin
                        req_q.aw_valid <= 1'b0;
                        req_q.w_valid  <= 1'b1;
                        req_q.w.data   <= step ? WakeMask : DataWidth'(entry_q);
                        state          <= WrW;
                    end
                end
                WrW: begin
                    if (rsp_i.w_ready) begin
                        req_q.w_valid <= 1'b0;
                        req_q.b_ready <= 1'b1;
                        state         <= WrB;
                    end
                end
                WrB: begin
                    if (rsp_i.b_valid) begin
                        req_q.b_ready <= 1'b0;
                        if (rsp_i.b.resp != 2'b00) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= Error;
                        end else if (!step) begin
                            step           <= 1'b1;
                            req_q.aw_valid <= 1'b1;
                            req_q.aw.addr  <= ClintSetAddr;
                            state          <= WrAw;
                        end else begin
                            gap_cnt <= '0;
                            state   <= Gap;
                        end
                    end
                end
                Gap: begin
                    // The interval is waited in full before every EOC read, the first included.
                    if (gap_cnt == PollInterval - 1) begin
                        gap_cnt        <= '0;
                        req_q.ar_valid <= 1'b1;
                        req_q.ar.addr  <= EocAddr;
                        state          <= RdAr;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                RdAr: begin
                    if (rsp_i.ar_ready) begin
                        req_q.ar_valid <= 1'b0;
                        req_q.r_ready  <= 1'b1;
                        state          <= RdR;
                    end
                end
                RdR: begin
                    if (rsp_i.r_valid) begin
                        req_q.r_ready <= 1'b0;
                        poll_cnt      <= poll_next;
                        if (rsp_i.r.resp != 2'b00) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= Error;
                        end else if (rsp_i.r.data[0]) begin
                            exit_code <= rsp_i.r.data[31:1];
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= Done;
                        end else if (PollTimeout != 0 && poll_next == PollTimeout) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= Error;
                        end else begin
                            state <= Gap;
                        end
                    end
                end
                Done:    state <= Done;
                Error:   state <= Error;
                default: state <= Idle;
            endcase
        end
    end

    assign req_o       = req_q;
    assign busy_o      = busy;
    assign done_o      = done;
    assign error_o     = error;
    assign exit_code_o = exit_code;

endmodule

// File: tb/tb_snitch_cluster_boot_master.sv
// Purpose: directed bench for the boot master against a small single-beat AXI slave model.
// Latency: checks start-to-AW of one cycle and three cycles per write.
// Backpressure: slave can stall AW/W readies to exercise valid/payload hold.

module tb_snitch_cluster_boot_master;
    import snitch_cluster_boot_master_pkg::*;

    localparam int unsigned PI = 4;
    localparam int unsigned PT = 3;
    localparam logic [47:0] SCRATCH = 48'h0000_0204_0010;
    localparam logic [47:0] CLINT   = 48'h0000_0204_0030;
    localparam logic [47:0] EOC     = 48'h0000_0204_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] entry = '0;
    axi_req_t    req;
    axi_rsp_t    rsp;
    logic        busy, done, error;
    logic [30:0] exit_code;

    always #5 clk = ~clk;

    snitch_cluster_boot_master #(
        .AddrWidth(48), .DataWidth(64), .NrCores(9),
        .Scratch1Addr(SCRATCH), .ClintSetAddr(CLINT), .EocAddr(EOC),
        .PollInterval(PI), .PollTimeout(PT),
        .req_t(axi_req_t), .rsp_t(axi_rsp_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .entry_i(entry),
        .req_o(req), .rsp_i(rsp), .busy_o(busy), .done_o(done),
        .error_o(error), .exit_code_o(exit_code)
    );

    // Slave configuration
    int          stall = 0;
    logic [1:0]  bresp_first = 2'b00;
    int          eoc_zeros = 0;
    logic [31:0] eoc_final = 32'h1;

    // Slave state and logs
    int          aw_wait, w_wait, aw_cnt, w_cnt, ar_cnt, cyc, last_ar_cyc, min_ar_gap, violations;
    logic        b_pend, r_pend;
    logic [1:0]  b_resp_q;
    logic [31:0] r_dat_q;
    logic [47:0] aw_addr_log [4];
    logic [63:0] w_dat_log [4];
    logic        aw_hold, w_hold, ar_hold;
    aw_chan_t    aw_prev;
    w_chan_t     w_prev;
    ar_chan_t    ar_prev;

    always_comb begin
        rsp          = '0;
        rsp.aw_ready = (aw_wait >= stall);
        rsp.w_ready  = (w_wait >= stall);
        rsp.ar_ready = 1'b1;
        rsp.b_valid  = b_pend;
        rsp.b.resp   = b_resp_q;
        rsp.r_valid  = r_pend;
        rsp.r.data   = {32'h0, r_dat_q};
        rsp.r.last   = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            cyc <= 0; last_ar_cyc <= 0; min_ar_gap <= 1000000; violations <= 0;
            b_pend <= 1'b0; r_pend <= 1'b0; b_resp_q <= 2'b00; r_dat_q <= '0;
            aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
            aw_prev <= '0; w_prev <= '0; ar_prev <= '0;
            for (int i = 0; i < 4; i++) begin
                aw_addr_log[i] <= '0;
                w_dat_log[i]   <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            if (req.aw_valid && rsp.aw_ready) begin
                if (aw_cnt < 4) aw_addr_log[aw_cnt] <= req.aw.addr;
                aw_cnt <= aw_cnt + 1;
                aw_wait <= 0;
            end else if (req.aw_valid) begin
                aw_wait <= aw_wait + 1;
            end
            if (req.w_valid && rsp.w_ready) begin
                if (w_cnt < 4) w_dat_log[w_cnt] <= req.w.data;
                w_cnt <= w_cnt + 1;
                w_wait <= 0;
                b_pend <= 1'b1;
                b_resp_q <= (w_cnt == 0) ? bresp_first : 2'b00;
            end else if (req.w_valid) begin
                w_wait <= w_wait + 1;
            end
            if (req.b_ready && b_pend) b_pend <= 1'b0;
            if (req.ar_valid && rsp.ar_ready) begin
                if (ar_cnt > 0 && (cyc - last_ar_cyc) < min_ar_gap) min_ar_gap <= cyc - last_ar_cyc;
                last_ar_cyc <= cyc;
                ar_cnt <= ar_cnt + 1;
                r_pend <= 1'b1;
                r_dat_q <= (ar_cnt < eoc_zeros) ? 32'h0 : eoc_final;
            end
            if (req.r_ready && r_pend) r_pend <= 1'b0;
            // Held valids must stay up with identical payload; channels never overlap.
            if ((aw_hold && (!req.aw_valid || req.aw != aw_prev)) ||
                (w_hold && (!req.w_valid || req.w != w_prev)) ||
                (ar_hold && (!req.ar_valid || req.ar != ar_prev)) ||
                (32'(req.aw_valid) + 32'(req.w_valid) + 32'(req.ar_valid) +
                 32'(req.b_ready) + 32'(req.r_ready) > 1))
                violations <= violations + 1;
            aw_hold <= req.aw_valid && !rsp.aw_ready;
            w_hold  <= req.w_valid && !rsp.w_ready;
            ar_hold <= req.ar_valid && !rsp.ar_ready;
            aw_prev <= req.aw;
            w_prev  <= req.w;
            ar_prev <= req.ar;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_end(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (done || error) break;
            tick();
        end
        check({name, "_finished"}, 64'(done | error), 64'd1);
    endtask

    typedef struct {
        logic [31:0] entry;
        int          stall;
        logic [1:0]  bresp;
        int          zeros;
        logic [31:0] final_v;
        logic        exp_done;
        logic        exp_err;
        logic [30:0] exp_exit;
        int          exp_aw;
        int          exp_ar;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h8000_0000, 0, 2'b00, 1,   32'h0000_0015, 1'b1, 1'b0, 31'd10,        2, 2};
        vecs[1] = '{32'h1234_5678, 7, 2'b00, 0,   32'h0000_002B, 1'b1, 1'b0, 31'h15,        2, 1};
        vecs[2] = '{32'hDEAD_BEEF, 0, 2'b10, 0,   32'h0000_0001, 1'b0, 1'b1, 31'd0,         1, 0};
        vecs[3] = '{32'h0000_0001, 0, 2'b00, 100, 32'h0000_0000, 1'b0, 1'b1, 31'd0,         2, 3};
        vecs[4] = '{32'hFFFF_FFFF, 3, 2'b00, 2,   32'hFFFF_FFFF, 1'b1, 1'b0, 31'h7FFF_FFFF, 2, 3};

        // Reset values
        do_reset();
        check("rst_req_zero", 64'(req == '0), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_exit", 64'(exit_code), 64'd0);

        // Table-driven full sequences
        for (int v = 0; v < 5; v++) begin
            string p;
            p = $sformatf("v%0d", v);
            stall       = vecs[v].stall;
            bresp_first = vecs[v].bresp;
            eoc_zeros   = vecs[v].zeros;
            eoc_final   = vecs[v].final_v;
            do_reset();
            entry = vecs[v].entry;
            pulse_start();
            run_to_end(p);
            tick();
            check({p, "_done"}, 64'(done), 64'(vecs[v].exp_done));
            check({p, "_error"}, 64'(error), 64'(vecs[v].exp_err));
            check({p, "_busy"}, 64'(busy), 64'd0);
            check({p, "_exit"}, 64'(exit_code), 64'(vecs[v].exp_exit));
            check({p, "_aw_count"}, 64'(aw_cnt), 64'(vecs[v].exp_aw));
            check({p, "_ar_count"}, 64'(ar_cnt), 64'(vecs[v].exp_ar));
            check({p, "_wr0_addr"}, 64'(aw_addr_log[0]), 64'(SCRATCH));
            check({p, "_wr0_data"}, w_dat_log[0], {32'h0, vecs[v].entry});
            if (vecs[v].exp_aw == 2) begin
                check({p, "_wr1_addr"}, 64'(aw_addr_log[1]), 64'(CLINT));
                check({p, "_wr1_data"}, w_dat_log[1], 64'h1FF);
            end
            if (vecs[v].exp_ar >= 2)
                check({p, "_ar_spacing"}, 64'(min_ar_gap >= int'(PI)), 64'd1);
            check({p, "_protocol"}, 64'(violations), 64'd0);
            check({p, "_valids_idle"},
                  64'(req.aw_valid | req.w_valid | req.ar_valid | req.b_ready | req.r_ready), 64'd0);
        end

        // Cycle-exact latency, start ignored while busy and in Done
        stall = 0; bresp_first = 2'b00; eoc_zeros = 1; eoc_final = 32'h15;
        do_reset();
        entry = 32'h8000_0000;
        pulse_start();
        check("lat_aw_valid", 64'(req.aw_valid), 64'd1);
        check("lat_aw_addr", 64'(req.aw.addr), 64'(SCRATCH));
        check("lat_aw_attr", {req.aw.len, 5'(req.aw.size), 6'(req.aw.burst), 48'(req.aw.id)}, {8'd0, 5'd3, 6'd1, 48'd0});
        check("lat_busy", 64'(busy), 64'd1);
        tick();
        check("lat_w_valid", 64'({req.aw_valid, req.w_valid}), 64'b01);
        check("lat_w_fields", {req.w.data[31:0], 23'd0, req.w.last, req.w.strb}, {32'h8000_0000, 23'd0, 1'b1, 8'hFF});
        tick();
        check("lat_b_ready", 64'({req.w_valid, req.b_ready}), 64'b01);
        tick();
        check("lat_aw2_valid", 64'(req.aw_valid), 64'd1);
        check("lat_aw2_addr", 64'(req.aw.addr), 64'(CLINT));
        tick(); tick(); tick();
        entry = 32'h5555_5555;
        pulse_start();
        run_to_end("ign");
        check("ign_done", 64'(done), 64'd1);
        check("ign_exit", 64'(exit_code), 64'd10);
        pulse_start();
        repeat (2 * PI + 6) tick();
        check("ign_aw_count", 64'(aw_cnt), 64'd2);
        check("ign_ar_count", 64'(ar_cnt), 64'd2);
        check("ign_exit_hold", 64'(exit_code), 64'd10);
        check("ign_busy", 64'(busy), 64'd0);

        // Asynchronous reset while W is pending, then restart from step 0
        stall = 20; eoc_zeros = 0; eoc_final = 32'h3;
        do_reset();
        entry = 32'hCAFE_0000;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (req.w_valid) break;
            tick();
        end
        check("mid_w_valid_seen", 64'(req.w_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_req_zero", 64'(req == '0), 64'd1);
        check("mid_status", 64'({busy, done, error}), 64'd0);
        check("mid_exit", 64'(exit_code), 64'd0);
        stall = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        entry = 32'h0000_4000;
        pulse_start();
        check("mid_restart_addr", 64'(req.aw.addr), 64'(SCRATCH));
        run_to_end("mid");
        tick();
        check("mid_restart_done", 64'(done), 64'd1);
        check("mid_restart_exit", 64'(exit_code), 64'd1);
        check("mid_restart_wr0", w_dat_log[0], 64'h4000);
        check("mid_restart_aw", 64'(aw_cnt), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
